controle_multiciclo: RTL



---
 rtl/controle_multiciclo.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch, decode, execute, memory, write-back and PC update,
// with bounded handshake waits, sticky error flag and a retired-instruction counter.
module controle_multiciclo #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_ready,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [3:0]       estado,
  output logic             pcsrc,
  output logic [11:0]      imediato,
  output logic             negativo,
  output logic             instr_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             erro,
  output logic [CNT_W-1:0] retiradas
);

  localparam int WT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    BUSCA = 4'b0001,
    DECOD = 4'b0010,
    EXEC  = 4'b0011,
    MEM   = 4'b0100,
    ESCR  = 4'b0101,
    PCUPD = 4'b1000
  } state_t;

  typedef enum logic [2:0] {
    CL_R  = 3'd0,
    CL_I  = 3'd1,
    CL_LD = 3'd2,
    CL_ST = 3'd3,
    CL_BR = 3'd4
  } cls_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [WT_W-1:0]         r_wait;
  logic [WT_W-1:0]         w_wait_nxt;
  logic                    w_wait_last;
  logic                    w_err_evt;
  logic                    r_erro;
  logic [CNT_W-1:0]        r_ret;
  logic                    r_pcsrc;
  logic                    r_neg;
  logic [11:0]             r_imm;
  cls_t                    r_cls;
  logic                    r_bne;

  // Fields latched at fetch; no reset needed, always written before DECOD reads them
  logic [6:0]              r_opcode;
  logic [2:0]              r_funct3;
  logic signed [12:0]      r_bimm;

  cls_t                    w_cls;
  logic                    w_bne;
  logic                    w_dec_err;
  logic [12:0]             w_mag;
  logic                    w_unused_regs;

  // Magnitude of the 13-bit branch offset; -4096 yields 13'h1000 (bit 12 set = out of range)
  function automatic logic [12:0] mag13(input logic signed [12:0] v);
    logic signed [12:0] n;
    n = -v;
    return v[12] ? $unsigned(n) : $unsigned(v);
  endfunction

  assign w_unused_regs = ^instr[24:15];
  assign w_wait_last   = (r_wait == WT_W'(WAIT_MAX - 1));
  assign w_mag         = mag13(r_bimm);

  always_ff @(posedge clk) begin
    if (r_state == BUSCA && instr_ready) begin
      r_opcode <= instr[6:0];
      r_funct3 <= instr[14:12];
      r_bimm   <= {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    end
  end

  always_comb begin
    w_cls     = CL_R;
    w_bne     = 1'b0;
    w_dec_err = 1'b0;
    case (r_opcode)
      7'b0110011: w_cls = CL_R;
      7'b0010011: w_cls = CL_I;
      7'b0000011: w_cls = CL_LD;
      7'b0100011: w_cls = CL_ST;
      7'b1100011: begin
        w_cls = CL_BR;
        if (r_funct3 == 3'b001)      w_bne = 1'b1;
        else if (r_funct3 != 3'b000) w_dec_err = 1'b1;
        if (w_mag[12])               w_dec_err = 1'b1;
      end
      default:    w_dec_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_err_evt = 1'b0;
    case (r_state)
      BUSCA: begin
        if (instr_ready) begin
          w_next = DECOD;
        end else if (w_wait_last) begin
          w_next    = PCUPD;
          w_err_evt = 1'b1;
        end
      end
      DECOD: begin
        if (w_dec_err) begin
          w_next    = PCUPD;
          w_err_evt = 1'b1;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: begin
        case (r_cls)
          CL_BR:        w_next = PCUPD;
          CL_LD, CL_ST: w_next = MEM;
          default:      w_next = ESCR;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          w_next = (r_cls == CL_LD) ? ESCR : PCUPD;
        end else if (w_wait_last) begin
          w_next    = PCUPD;
          w_err_evt = 1'b1;
        end
      end
      ESCR:    w_next = PCUPD;
      PCUPD:   w_next = BUSCA;
      default: w_next = BUSCA;
    endcase
  end

  // The wait counter only runs while a handshake state holds; any transition clears it
  assign w_wait_nxt = ((r_state == BUSCA || r_state == MEM) && w_next == r_state)
                      ? r_wait + WT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUSCA;
      r_wait  <= '0;
      r_erro  <= 1'b0;
      r_ret   <= '0;
      r_pcsrc <= 1'b0;
      r_neg   <= 1'b0;
      r_imm   <= '0;
      r_cls   <= CL_R;
      r_bne   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_err_evt) r_erro <= 1'b1;
      if (r_state == PCUPD) r_ret <= r_ret + CNT_W'(1);
      case (r_state)
        DECOD: begin
          r_cls <= w_cls;
          r_bne <= w_bne;
          r_neg <= (w_cls == CL_BR) ? r_bimm[12] : 1'b0;
          r_imm <= (w_cls == CL_BR) ? w_mag[11:0] : 12'd0;
        end
        EXEC: begin
          if (r_cls == CL_BR) r_pcsrc <= r_bne ? ~zero : zero;
        end
        PCUPD:   r_pcsrc <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_req = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    alu_src   = 1'b0;
    case (r_state)
      BUSCA: instr_req = 1'b1;
      EXEC: begin
        alu_src = (r_cls == CL_I) || (r_cls == CL_LD) || (r_cls == CL_ST);
        case (r_cls)
          CL_BR:      alu_op = 2'b01;
          CL_R, CL_I: alu_op = 2'b10;
          default:    alu_op = 2'b00;
        endcase
      end
      MEM: begin
        mem_read  = (r_cls == CL_LD);
        mem_write = (r_cls == CL_ST);
      end
      ESCR:    reg_write = 1'b1;
      default: ;
    endcase
  end

  assign estado    = r_state;
  assign pcsrc     = r_pcsrc;
  assign imediato  = r_imm;
  assign negativo  = r_neg;
  assign erro      = r_erro;
  assign retiradas = r_ret;

endmodule
